// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM duty-ramp block.
// - Duty width and the default duty clamp.
// - Ramp state encoding.
// - System clock rate, used to derive STEP_TICKS from a step period.
// - A helper that clamps a requested duty.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int DUTY_W   = 8;
  localparam int DUTY_MAX = 100;
  localparam int CLK_HZ   = 100_000_000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_UP   = 3'd2,
    ST_DN   = 3'd3,
    ST_STOP = 3'd4
  } ramp_state_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v,
                                                   input logic [DUTY_W-1:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// STEP_TICKS prescaler: counts 0..STEP_TICKS-1 while enabled and emits a
// one-cycle terminal pulse on the last count.
// Ports:
//   I_clk   system clock
//   I_rst_n synchronous active-low reset
//   I_clr   synchronous clear (wins over counting, suppresses the pulse)
//   I_en    count enable; the counter is held at 0 while low
//   O_tick  one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module pwm_tick_gen #(
  parameter int unsigned STEP_TICKS = 1_000_000
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_clr,
  input  logic I_en,
  output logic O_tick
);

  localparam logic [31:0] TERM = 32'(STEP_TICKS - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // >= rather than == so a corrupted count can never run past the terminal value
  assign O_tick = I_en && !I_clr && (cnt_q >= TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (I_clr || !I_en || O_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// pwm_duty_ramp
// Slew-limited duty generator for the PWM output stage. A target duty is
// accepted over valid/ready; the output duty then moves toward it by one
// percent every STEP_TICKS clocks.
// Optional feature macro: PWM_RAMP_SOFTSTOP_EN -- when defined, dropping I_en
// ramps the duty down to 0 (STOP state) instead of cutting it at once.
// Ports:
//   I_clk, I_rst_n       clock, synchronous active-low reset
//   I_en                 block enable
//   I_target_vld/I_target, O_target_rdy   target handshake (clamped to DUTY_MAX)
//   O_duty               current duty 0..DUTY_MAX
//   O_pwm_en             PWM stage enable
//   O_busy               high while ramping (UP/DN/STOP)
//   O_done               one-cycle pulse when the duty lands on the target
//   O_clamp              one-cycle pulse when an accepted target was clamped
// -----------------------------------------------------------------------------
module pwm_duty_ramp #(
  parameter int unsigned STEP_TICKS = 1_000_000,
  parameter int unsigned DUTY_MAX   = pwm_pkg::DUTY_MAX
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_en,
  input  logic       I_target_vld,
  input  logic [7:0] I_target,
  output logic       O_target_rdy,
  output logic [7:0] O_duty,
  output logic       O_pwm_en,
  output logic       O_busy,
  output logic       O_done,
  output logic       O_clamp
);

  import pwm_pkg::*;

  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] ONE  = DUTY_W'(1);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pwm_en_q, pwm_en_d;
  logic              done_q, done_d;
  logic              clamp_q, clamp_d;

  logic              xfer;
  logic              tick;
  logic              tick_clr;
  logic              tick_en;
  logic [DUTY_W-1:0] new_target;

  assign O_target_rdy = I_en && (state_q != ST_STOP);
  assign xfer         = I_target_vld && O_target_rdy;
  assign new_target   = clamp_duty(I_target, DMAX);
  assign tick_en      = (state_q == ST_UP) || (state_q == ST_DN) || (state_q == ST_STOP);

  pwm_tick_gen #(
    .STEP_TICKS(STEP_TICKS)
  ) u_tick_gen (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_clr  (tick_clr),
    .I_en   (tick_en),
    .O_tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    duty_d   = duty_q;
    pwm_en_d = pwm_en_q;
    done_d   = 1'b0;
    clamp_d  = 1'b0;
    tick_clr = 1'b0;

    if (!I_en) begin
`ifdef PWM_RAMP_SOFTSTOP_EN
      if (state_q == ST_STOP) begin
        if (tick) begin
          if (duty_q != '0) duty_d = duty_q - ONE;
          if (duty_d == '0) begin
            state_d  = ST_IDLE;
            pwm_en_d = 1'b0;
            target_d = '0;
            done_d   = 1'b1;
          end
        end
      end else if (state_q != ST_IDLE) begin
        if (duty_q != '0) begin
          // target is kept so a re-enable can resume toward it
          state_d  = ST_STOP;
          tick_clr = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          pwm_en_d = 1'b0;
          target_d = '0;
        end
      end
`else
      state_d  = ST_IDLE;
      duty_d   = '0;
      pwm_en_d = 1'b0;
      target_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_HOLD;
          pwm_en_d = 1'b1;
          target_d = '0;
          duty_d   = '0;
        end
`ifdef PWM_RAMP_SOFTSTOP_EN
        ST_STOP: begin
          tick_clr = 1'b1;
          if (target_q > duty_q)      state_d = ST_UP;
          else if (target_q < duty_q) state_d = ST_DN;
          else                        state_d = ST_HOLD;
        end
`endif
        ST_UP: begin
          if (tick) begin
            if (duty_q < target_q) duty_d = duty_q + ONE;
            if (duty_d >= target_q) begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end
          end
        end
        ST_DN: begin
          if (tick) begin
            if (duty_q > target_q) duty_d = duty_q - ONE;
            if (duty_d <= target_q) begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase

      // A transfer overrides any step scheduled for this cycle; direction is
      // taken from the duty currently on the output so it never jumps.
      if (xfer) begin
        duty_d   = duty_q;
        done_d   = 1'b0;
        target_d = new_target;
        clamp_d  = (I_target > DMAX);
        tick_clr = 1'b1;
        if (new_target > duty_q) begin
          state_d = ST_UP;
        end else if (new_target < duty_q) begin
          state_d = ST_DN;
        end else begin
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      duty_q   <= '0;
      pwm_en_q <= 1'b0;
      done_q   <= 1'b0;
      clamp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      pwm_en_q <= pwm_en_d;
      done_q   <= done_d;
      clamp_q  <= clamp_d;
    end
  end

  assign O_duty   = duty_q;
  assign O_pwm_en = pwm_en_q;
  assign O_busy   = tick_en;
  assign O_done   = done_q;
  assign O_clamp  = clamp_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_ramp
// Directed bench for pwm_duty_ramp with STEP_TICKS=4. Inputs are driven and
// outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_duty_ramp;

  localparam int unsigned STEP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       vld;
  logic [7:0] tgt;
  logic       rdy;
  logic [7:0] duty;
  logic       pwm_en;
  logic       busy;
  logic       done;
  logic       clamp;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(
    .STEP_TICKS(STEP),
    .DUTY_MAX  (100)
  ) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_en        (en),
    .I_target_vld(vld),
    .I_target    (tgt),
    .O_target_rdy(rdy),
    .O_duty      (duty),
    .O_pwm_en    (pwm_en),
    .O_busy      (busy),
    .O_done      (done),
    .O_clamp     (clamp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] t);
    vld = 1'b1;
    tgt = t;
    step1();
    vld = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      step1();
      cyc++;
      if (done) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int dn;
    int cl;
    int mx;
    int done_k;

    rst_n = 1'b0;
    en    = 1'b0;
    vld   = 1'b0;
    tgt   = 8'd0;
    step1();
    step1();
    check_eq("rst_duty",   duty,   0);
    check_eq("rst_pwm_en", pwm_en, 0);
    check_eq("rst_busy",   busy,   0);
    check_eq("rst_done",   done,   0);
    check_eq("rst_clamp",  clamp,  0);
    check_eq("rst_rdy",    rdy,    0);

    // enable: IDLE -> HOLD, pwm enable one cycle later
    rst_n = 1'b1;
    en    = 1'b1;
    step1();
    check_eq("en_pwm_en", pwm_en, 1);
    check_eq("en_busy",   busy,   0);
    check_eq("en_rdy",    rdy,    1);

    // ramp 0 -> 10, one step per 4 clocks, done at cycle 40
    send(8'd10);
    check_eq("up10_busy", busy, 1);
    check_eq("up10_duty0", duty, 0);
    for (int k = 1; k <= 40; k++) begin
      step1();
      check_eq($sformatf("up10_duty_k%0d", k), duty, 32'(k / 4));
      check_eq($sformatf("up10_done_k%0d", k), done, (k == 40) ? 1 : 0);
    end
    check_eq("up10_hold_busy", busy, 0);
    step1();
    check_eq("up10_done_clr", done, 0);

    // clamp 150 -> 100, 90 steps
    send(8'd150);
    check_eq("clamp_pulse", clamp, 1);
    check_eq("clamp_busy",  busy,  1);
    check_eq("clamp_duty0", duty,  10);
    mx = 0; dn = 0; cl = 0; done_k = 0;
    for (int k = 1; k <= 360; k++) begin
      step1();
      if (int'(duty) > mx) mx = int'(duty);
      if (done) begin dn++; done_k = k; end
      if (clamp) cl++;
    end
    check_eq("clamp_final", duty,   100);
    check_eq("clamp_max",   mx,     100);
    check_eq("clamp_ndone", dn,     1);
    check_eq("clamp_donek", done_k, 360);
    check_eq("clamp_once",  cl,     0);

    // down to 0, then reverse mid-ramp
    send(8'd0);
    wait_done(410, c);
    check_eq("dn0_done",   done, 1);
    check_eq("dn0_cycles", c,    400);
    check_eq("dn0_duty",   duty, 0);
    send(8'd50);
    dn = 0;
    for (int k = 1; k <= 80; k++) begin
      step1();
      if (done) dn++;
    end
    check_eq("rev_at20",  duty, 20);
    check_eq("rev_nodone", dn,  0);
    send(8'd5);
    check_eq("rev_nojump", duty, 20);
    check_eq("rev_busy",   busy, 1);
    dn = 0;
    for (int k = 1; k <= 60; k++) begin
      step1();
      if (k == 4) check_eq("rev_first", duty, 19);
      if (done) dn++;
    end
    check_eq("rev_final", duty, 5);
    check_eq("rev_ndone", dn,   1);

    // transfer on the terminal-tick cycle suppresses that step
    send(8'd12);
    step1(); step1(); step1();
    check_eq("tt_pre", duty, 5);
    send(8'd12);
    check_eq("tt_nostep", duty, 5);
    step1(); step1(); step1();
    check_eq("tt_wait", duty, 5);
    step1();
    check_eq("tt_step", duty, 6);
    wait_done(40, c);
    check_eq("tt_cycles", c,    24);
    check_eq("tt_final",  duty, 12);

    // drop enable at duty 30
    send(8'd30);
    wait_done(90, c);
    check_eq("d30_cycles", c,    72);
    check_eq("d30_duty",   duty, 30);
    en = 1'b0;
    step1();
`ifdef PWM_RAMP_SOFTSTOP_EN
    check_eq("soft_pwm_en", pwm_en, 1);
    check_eq("soft_busy",   busy,   1);
    check_eq("soft_rdy",    rdy,    0);
    check_eq("soft_duty",   duty,   30);
    wait_done(140, c);
    check_eq("soft_cycles", c,      120);
    check_eq("soft_final",  duty,   0);
    check_eq("soft_pwm_off", pwm_en, 0);
`else
    check_eq("off_duty",   duty,   0);
    check_eq("off_pwm_en", pwm_en, 0);
    check_eq("off_busy",   busy,   0);
    check_eq("off_done",   done,   0);
`endif
    step1();
    check_eq("off_rdy", rdy, 0);

    // reset mid-ramp
    en = 1'b1;
    step1();
    check_eq("re_pwm_en", pwm_en, 1);
    check_eq("re_duty",   duty,   0);
    send(8'd40);
    repeat (20) step1();
    check_eq("mid_duty", duty, 5);
    rst_n = 1'b0;
    step1();
    rst_n = 1'b1;
    check_eq("mrst_duty",   duty,   0);
    check_eq("mrst_pwm_en", pwm_en, 0);
    check_eq("mrst_busy",   busy,   0);
    check_eq("mrst_done",   done,   0);
    check_eq("mrst_clamp",  clamp,  0);
    step1();
    check_eq("mrst_hold_pwm", pwm_en, 1);
    check_eq("mrst_hold_busy", busy,  0);
    check_eq("mrst_hold_duty", duty,  0);
    check_eq("mrst_rdy",       rdy,   1);
    send(8'd0);
    check_eq("eq_done", done, 1);
    check_eq("eq_busy", busy, 0);
    step1();
    check_eq("eq_done_clr", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Soft-start / slew-limited duty-cycle generator that feeds the PWM output stage's 8-bit percent input (0-100) and its enable.
- Accepts a target duty over a valid/ready handshake.
- Moves its output duty toward the target one percent at a time, one step every STEP_TICKS clocks.
- Prevents load current steps when firmware changes duty abruptly.

Parameters:
- STEP_TICKS, 1_000_000, clocks per 1% step (10 ms at 100 MHz); legal range 1 to 2^32-1.
- DUTY_MAX, 100, upper clamp for target and output duty.

Ports:
- I_clk  in  1  system clock, 100 MHz.
- I_rst_n  in  1  reset, synchronous, active-low.
- I_en  in  1  block enable, active high.
- I_target_vld  in  1  target valid.
- I_target  in  8  requested duty percent; values above DUTY_MAX are clamped.
- O_target_rdy  out  1  target ready.
- O_duty  out  8  current duty to the PWM stage, always 0..DUTY_MAX.
- O_pwm_en  out  1  enable to the PWM stage.
- O_busy  out  1  high while ramping.
- O_done  out  1  one-cycle pulse when O_duty reaches the target.
- O_clamp  out  1  one-cycle pulse when an accepted I_target exceeded DUTY_MAX.

Behaviour:
- Clock and reset: one clock, I_clk; reset I_rst_n is synchronous and active-low, sampled only on the I_clk rising edge.
- Reset values: state IDLE; target register 0; tick counter 0; O_duty 0; O_pwm_en 0; O_busy 0; O_done 0; O_clamp 0.
- Reset mid-ramp: abandons the ramp immediately.
- States:
  - IDLE: I_en=0; O_duty 0, O_pwm_en 0.
  - HOLD: O_duty == target.
  - UP: ramping up.
  - DN: ramping down.
  - STOP: only when PWM_RAMP_SOFTSTOP_EN is defined.
- IDLE -> HOLD on I_en=1, with target 0 and duty 0; O_pwm_en goes to 1 the next cycle.
- O_target_rdy = I_en && state != STOP. It is combinational; a transfer occurs when I_target_vld && O_target_rdy.
- On transfer:
  - target <= min(I_target, DUTY_MAX).
  - O_clamp pulses the following cycle if I_target > DUTY_MAX.
  - Tick counter cleared.
  - Next state is UP if target > O_duty, DN if target < O_duty, otherwise HOLD with an O_done pulse next cycle.
- A transfer is allowed in any non-IDLE state, including mid-ramp (retarget). Direction is recomputed from the current O_duty; O_duty does not jump.
- UP/DN:
  - Tick counter counts 0..STEP_TICKS-1.
  - On terminal count, O_duty += 1 (UP) or -= 1 (DN) and the counter clears.
  - The cycle in which the updated O_duty equals target: state -> HOLD, O_done = 1 for exactly one cycle, aligned with the final O_duty value.
- Latency: first step lands STEP_TICKS cycles after the transfer cycle; full ramp takes |target - duty_at_transfer| * STEP_TICKS cycles.
- O_busy = 1 in UP, DN and STOP; otherwise 0.
- Transfer coinciding with a terminal tick: the transfer wins; counter clears and no step occurs that cycle.
- STEP_TICKS=1: one step per clock.
- Arithmetic: O_duty never wraps or leaves 0..DUTY_MAX. Counter is 32 bits, compared with >= (STEP_TICKS-1) for robustness.
- I_en falling (macro not defined): next cycle state IDLE, O_duty 0, O_pwm_en 0, O_busy 0, target 0; no O_done.

Optional Feature:
- Macro: PWM_RAMP_SOFTSTOP_EN.
- Defined:
  - I_en falling with O_duty > 0 enters STOP: ramp down at STEP_TICKS rate, O_pwm_en held 1, O_target_rdy 0.
  - At O_duty == 0: IDLE, O_pwm_en 0, O_done pulse.
  - I_en falling with O_duty == 0 goes straight to IDLE.
  - I_en re-asserted during STOP: keep the retained target, go to UP/DN/HOLD from the current O_duty, counter cleared.
- Not defined: immediate shutdown as in Behaviour; no STOP state is synthesized.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W = 8, DUTY_MAX = 100.
  - Ramp state enum (IDLE, HOLD, UP, DN, STOP).
  - 100 MHz clock constant for deriving STEP_TICKS.
- Sub-module pwm_tick_gen:
  - Parameterised STEP_TICKS prescaler with synchronous clear and enable; outputs a one-cycle terminal pulse.
  - pwm_duty_ramp instantiates one.

Test Plan:
- STEP_TICKS=4: enable, send target 10 -> O_busy high; O_duty increments every 4 clocks; O_duty=10 at cycle 40 after transfer with a coincident 1-cycle O_done; then HOLD.
- From duty 10, send target 150 -> target 100, O_clamp one pulse, ramp 90 steps to 100; O_duty never exceeds 100.
- Ramping up toward 50, at duty 20 send target 5 -> direction reverses with no jump; reaches 5 after 15*STEP_TICKS cycles, single O_done.
- Transfer on the exact terminal-tick cycle -> no step that cycle; next step STEP_TICKS cycles later.
- Drop I_en at duty 30: without the macro, O_duty=0 and O_pwm_en=0 next cycle. With PWM_RAMP_SOFTSTOP_EN, 30 down-steps, O_pwm_en held until duty 0, O_target_rdy low throughout.
- Assert I_rst_n=0 for one cycle mid-ramp -> on the next edge all outputs return to reset values; re-enable starts in HOLD at duty 0.
